// File: rtl/psram_pkg.sv
// psram_pkg: shared state encoding and command constants for the PSRAM scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package psram_pkg;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_WAIT_INIT,
    ST_READY,
    ST_WR_ISSUE,
    ST_WR_BUSY,
    ST_RD_ISSUE,
    ST_RD_BUSY
  } state_t;

  localparam logic [1:0] RW_NONE  = 2'd0;
  localparam logic [1:0] RW_WRITE = 2'd1;
  localparam logic [1:0] RW_READ  = 2'd2;

  // Minimum words left in memory for a write to be allowed to burst from the FIFO
  localparam int BURST_GUARD = 128;

endpackage

// File: rtl/psram_arbiter.sv
// psram_arbiter: two-requester grant (write vs read) with alternating priority on contention.
// Latency: combinational; the caller registers the decision.
// Backpressure: a losing request is simply not granted and stays pending.
module psram_arbiter (
  input  logic wr_elig,
  input  logic rd_elig,
  input  logic last_rd,
  output logic gnt_wr,
  output logic gnt_rd
);

  // A lone request always wins; on contention the type not served last wins
  always_comb begin
    gnt_wr = wr_elig & (~rd_elig | last_rd);
    gnt_rd = rd_elig & (~wr_elig | ~last_rd);
  end

endmodule

// File: rtl/psram_scheduler.sv
// psram_scheduler: waits for QPI init, owns PSRAM write/read pointers, issues one write or read command at a time.
// Latency: request to quad_start 2 cycles; rd_valid 1 cycle after the read's endcommand; mem_full 1 cycle after last word.
// Backpressure: requests wait in READY while a command is in flight; writes stop when FIFO empty or memory full.
// Optional feature macro PSRAM_SCHED_WATCHDOG_EN: BUSY-state timeout sets sticky err and re-enters DRAIN.
module psram_scheduler
  import psram_pkg::*;
#(
  parameter int ADDR_W       = 23,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_STEP    = 2,
  parameter int MEM_WORDS    = 4194304,
  parameter int DRAIN_CYCLES = 512,
  parameter int WDOG_CYCLES  = 1024
) (
  input  logic                  clk_PSRAM,
  input  logic                  rst,
  input  logic                  qpi_on,
  input  logic                  endcommand,
  input  logic                  next_write,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  fifo_empty,
  input  logic                  acq_enable,
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic                  quad_start,
  output logic [1:0]            read_write,
  output logic [ADDR_W-1:0]     address,
  output logic                  burst_mode,
  output logic                  stop_acquisition,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_W-1:0]     wr_ptr,
  output logic                  mem_full,
  output logic                  busy,
  output logic                  err
);

  localparam int CNT_W = $clog2(MEM_WORDS + 1);
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

  state_t           state;
  logic             last_rd;
  logic [CNT_W-1:0] word_cnt;
  logic [DRN_W-1:0] drain_cnt;
  logic             wr_elig;
  logic             gnt_wr;
  logic             gnt_rd;
  logic             last_word;
  logic             full_nxt;
  logic             wdog_hit;

  assign wr_elig   = acq_enable & ~fifo_empty & ~mem_full;
  assign last_word = (state == ST_WR_BUSY) && next_write && !mem_full
                     && (int'(word_cnt) == MEM_WORDS - 1);
  assign full_nxt  = mem_full | last_word;

  psram_arbiter u_arb (
    .wr_elig (wr_elig),
    .rd_elig (rd_req),
    .last_rd (last_rd),
    .gnt_wr  (gnt_wr),
    .gnt_rd  (gnt_rd)
  );

`ifdef PSRAM_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_cnt;
  logic            err_q;

  assign wdog_hit = ((state == ST_WR_BUSY) || (state == ST_RD_BUSY))
                    && (int'(wdog_cnt) == WDOG_CYCLES - 1) && !endcommand;
  assign err      = err_q;

  // Count cycles spent waiting on a command; a timeout latches err until reset
  always_ff @(posedge clk_PSRAM) begin
    if (rst) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state == ST_WR_BUSY) || (state == ST_RD_BUSY)) wdog_cnt <= wdog_cnt + WD_W'(1);
      else                                                  wdog_cnt <= '0;
      if (wdog_hit) err_q <= 1'b1;
    end
  end
`else
  // Watchdog compiled out: BUSY states wait for endcommand indefinitely
  assign wdog_hit = (WDOG_CYCLES < 0);
  assign err      = 1'b0;
`endif

  // Main sequencer: drain, init wait, arbitration, command issue and completion
  always_ff @(posedge clk_PSRAM) begin
    if (rst) begin
      state            <= ST_DRAIN;
      drain_cnt        <= '0;
      last_rd          <= 1'b1;
      word_cnt         <= '0;
      wr_ptr           <= '0;
      mem_full         <= 1'b0;
      quad_start       <= 1'b0;
      read_write       <= RW_NONE;
      address          <= '0;
      burst_mode       <= 1'b0;
      stop_acquisition <= 1'b0;
      rd_ack           <= 1'b0;
      rd_valid         <= 1'b0;
      rd_data          <= '0;
      busy             <= 1'b1;
    end else begin
      quad_start       <= 1'b0;
      rd_ack           <= 1'b0;
      rd_valid         <= 1'b0;
      busy             <= 1'b1;
      stop_acquisition <= (state != ST_DRAIN) && (full_nxt || !acq_enable);
      if (last_word) mem_full <= 1'b1;
      // A word written in the same cycle as endcommand still advances the pointer
      if (state == ST_WR_BUSY && next_write) begin
        wr_ptr <= wr_ptr + ADDR_W'(ADDR_STEP);
        if (!mem_full) word_cnt <= word_cnt + CNT_W'(1);
      end
      case (state)
        ST_DRAIN: begin
          if (int'(drain_cnt) == DRAIN_CYCLES - 1) begin
            drain_cnt <= '0;
            state     <= ST_WAIT_INIT;
          end else begin
            drain_cnt <= drain_cnt + DRN_W'(1);
          end
        end
        ST_WAIT_INIT: begin
          if (qpi_on) begin
            state <= ST_READY;
            busy  <= 1'b0;
          end
        end
        ST_READY: begin
          if (gnt_wr) begin
            state   <= ST_WR_ISSUE;
            last_rd <= 1'b0;
          end else if (gnt_rd) begin
            state   <= ST_RD_ISSUE;
            last_rd <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_WR_ISSUE: begin
          quad_start <= 1'b1;
          read_write <= RW_WRITE;
          address    <= wr_ptr;
          burst_mode <= ((int'(word_cnt) + BURST_GUARD) <= MEM_WORDS);
          state      <= ST_WR_BUSY;
        end
        ST_RD_ISSUE: begin
          rd_ack     <= 1'b1;
          quad_start <= 1'b1;
          read_write <= RW_READ;
          address    <= rd_addr;
          state      <= ST_RD_BUSY;
        end
        ST_WR_BUSY, ST_RD_BUSY: begin
          if (endcommand || wdog_hit) begin
            read_write <= RW_NONE;
            address    <= '0;
            burst_mode <= 1'b0;
          end
          if (endcommand) begin
            state <= ST_READY;
            busy  <= 1'b0;
            if (state == ST_RD_BUSY) begin
              rd_data  <= data_out;
              rd_valid <= 1'b1;
            end
          end else if (wdog_hit) begin
            state <= ST_DRAIN;
          end
        end
        default: state <= ST_DRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_scheduler.sv
// tb_psram_scheduler: directed vector table plus hand sequences for arbitration, memory-full and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_psram_scheduler;
  import psram_pkg::*;

  localparam int AW = 23;
  localparam int DW = 16;
  localparam int MW = 133;
  localparam int DC = 8;
  localparam int WD = 16;

  logic          clk_PSRAM = 1'b0;
  logic          rst = 1'b1;
  logic          qpi_on = 1'b0;
  logic          endcommand = 1'b0;
  logic          next_write = 1'b0;
  logic [DW-1:0] data_out = '0;
  logic          fifo_empty = 1'b1;
  logic          acq_enable = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          quad_start, burst_mode, stop_acquisition, rd_ack, rd_valid, mem_full, busy, err;
  logic [1:0]    read_write;
  logic [AW-1:0] address, wr_ptr;
  logic [DW-1:0] rd_data;

  int checks = 0;
  int failures = 0;

  psram_scheduler #(
    .ADDR_W(AW), .DATA_WIDTH(DW), .ADDR_STEP(2), .MEM_WORDS(MW),
    .DRAIN_CYCLES(DC), .WDOG_CYCLES(WD)
  ) dut (
    .clk_PSRAM(clk_PSRAM), .rst(rst), .qpi_on(qpi_on), .endcommand(endcommand),
    .next_write(next_write), .data_out(data_out), .fifo_empty(fifo_empty),
    .acq_enable(acq_enable), .rd_req(rd_req), .rd_addr(rd_addr),
    .quad_start(quad_start), .read_write(read_write), .address(address),
    .burst_mode(burst_mode), .stop_acquisition(stop_acquisition), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data), .wr_ptr(wr_ptr), .mem_full(mem_full),
    .busy(busy), .err(err)
  );

  always #5 clk_PSRAM = ~clk_PSRAM;

  // ctl = {acq_enable, fifo_empty, rd_req, next_write, endcommand}
  // flg = {quad_start, rd_ack, rd_valid, burst_mode, stop_acquisition, busy}
  typedef struct {
    logic [4:0]    ctl;
    logic [AW-1:0] raddr;
    logic [DW-1:0] dout;
    logic [5:0]    flg;
    logic [1:0]    rw;
    logic [AW-1:0] addr;
    logic [AW-1:0] ptr;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t tbl [14];

  task automatic tick();
    @(posedge clk_PSRAM);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_quad(input string nm, output logic [1:0] rw, output logic bm);
    int n;
    n = 0;
    while (!quad_start && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!quad_start) begin
      failures++;
      $display("FAIL %s: quad_start got 0 expected 1 within 20 cycles", nm);
    end
    rw = read_write;
    bm = burst_mode;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] rw;
    logic       bm;
    logic [1:0] exp_rw [4];
    int         nq;

    exp_rw = '{RW_WRITE, RW_READ, RW_WRITE, RW_READ};

    //            ctl       raddr     dout      flg        rw  addr      ptr    rdata
    tbl[0]  = '{5'b10000, 23'h0,   16'h0,    6'b000001, 2'd0, 23'h0,   23'd0,  16'h0};
    tbl[1]  = '{5'b10000, 23'h0,   16'h0,    6'b100101, 2'd1, 23'h0,   23'd0,  16'h0};
    tbl[2]  = '{5'b10010, 23'h0,   16'h0,    6'b000101, 2'd1, 23'h0,   23'd2,  16'h0};
    tbl[3]  = '{5'b10010, 23'h0,   16'h0,    6'b000101, 2'd1, 23'h0,   23'd4,  16'h0};
    tbl[4]  = '{5'b10000, 23'h0,   16'h0,    6'b000101, 2'd1, 23'h0,   23'd4,  16'h0};
    tbl[5]  = '{5'b10010, 23'h0,   16'h0,    6'b000101, 2'd1, 23'h0,   23'd6,  16'h0};
    tbl[6]  = '{5'b10010, 23'h0,   16'h0,    6'b000101, 2'd1, 23'h0,   23'd8,  16'h0};
    tbl[7]  = '{5'b11011, 23'h0,   16'h0,    6'b000000, 2'd0, 23'h0,   23'd10, 16'h0};
    tbl[8]  = '{5'b11000, 23'h0,   16'h0,    6'b000000, 2'd0, 23'h0,   23'd10, 16'h0};
    tbl[9]  = '{5'b11100, 23'h100, 16'h0,    6'b000001, 2'd0, 23'h0,   23'd10, 16'h0};
    tbl[10] = '{5'b11100, 23'h100, 16'h0,    6'b110001, 2'd2, 23'h100, 23'd10, 16'h0};
    tbl[11] = '{5'b11000, 23'h100, 16'h0,    6'b000001, 2'd2, 23'h100, 23'd10, 16'h0};
    tbl[12] = '{5'b11001, 23'h100, 16'hABCD, 6'b001000, 2'd0, 23'h0,   23'd10, 16'hABCD};
    tbl[13] = '{5'b11000, 23'h100, 16'h0,    6'b000000, 2'd0, 23'h0,   23'd10, 16'hABCD};

    // Reset values
    repeat (3) tick();
    chk("reset_state",
        {quad_start, read_write, address, burst_mode, stop_acquisition, rd_ack, rd_valid,
         rd_data, wr_ptr, mem_full, busy, err},
        {1'b0, 2'd0, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 23'h0, 1'b0, 1'b1, 1'b0});
    rst = 1'b0;

    // qpi_on low: stays out of READY past the drain period
    repeat (20) tick();
    chk("wait_init_busy", busy, 1'b1);
    qpi_on = 1'b1;
    tick();
    chk("init_done_busy", busy, 1'b0);

    // Vector table: 5-word write ending with coincident next_write/endcommand, then a read
    for (int i = 0; i < 14; i++) begin
      {acq_enable, fifo_empty, rd_req, next_write, endcommand} = tbl[i].ctl;
      rd_addr  = tbl[i].raddr;
      data_out = tbl[i].dout;
      tick();
      chk($sformatf("vec%0d", i),
          {quad_start, rd_ack, rd_valid, burst_mode, stop_acquisition, busy,
           read_write, address, wr_ptr, rd_data},
          {tbl[i].flg, tbl[i].rw, tbl[i].addr, tbl[i].ptr, tbl[i].rdata});
    end
    {acq_enable, fifo_empty, rd_req, next_write, endcommand} = 5'b00000;
    fifo_empty = 1'b1;

    // Both requests pending: grants alternate, write first; burst_mode drops at 127 words left
    acq_enable = 1'b1; fifo_empty = 1'b0; rd_req = 1'b1; rd_addr = 23'h200;
    for (int k = 0; k < 4; k++) begin
      wait_quad($sformatf("alt%0d_start", k), rw, bm);
      chk($sformatf("alt%0d_rw", k), rw, exp_rw[k]);
      if (rw == RW_WRITE) begin
        chk($sformatf("alt%0d_burst", k), bm, (k == 0) ? 1'b1 : 1'b0);
        next_write = 1'b1;
      end
      data_out   = 16'h1000 + 16'(k);
      endcommand = 1'b1;
      tick();
      next_write = 1'b0;
      endcommand = 1'b0;
      if (rw == RW_READ)
        chk($sformatf("alt%0d_rdata", k), {rd_valid, rd_data}, {1'b1, 16'h1000 + 16'(k)});
    end
    rd_req = 1'b0;
    chk("alt_wr_ptr", wr_ptr, 23'd14);

    // Fill remaining 126 words: mem_full/stop appear the cycle after the last word
    wait_quad("fill_start", rw, bm);
    chk("fill_cmd", {rw, bm}, {RW_WRITE, 1'b0});
    for (int n = 1; n <= 126; n++) begin
      next_write = 1'b1;
      tick();
      if (n == 125) chk("full_before_last", {mem_full, stop_acquisition}, 2'b00);
      if (n == 126) chk("full_after_last", {mem_full, stop_acquisition}, 2'b11);
    end
    next_write = 1'b0;
    endcommand = 1'b1;
    tick();
    endcommand = 1'b0;
    chk("full_wr_ptr", wr_ptr, 23'd266);
    nq = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (quad_start) nq++;
    end
    chk("no_write_when_full", {nq[7:0], busy, mem_full}, {8'd0, 1'b0, 1'b1});

    // Reads still served while full; then reset lands mid-RD_BUSY
    rd_req = 1'b1; rd_addr = 23'h300;
    wait_quad("full_read_start", rw, bm);
    chk("full_read_cmd", {rw, rd_ack, address}, {RW_READ, 1'b1, 23'h300});
    rd_req = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acq_enable = 1'b0;
    chk("mid_read_reset",
        {quad_start, read_write, address, burst_mode, stop_acquisition, rd_ack, rd_valid,
         rd_data, wr_ptr, mem_full, busy, err},
        {1'b0, 2'd0, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 23'h0, 1'b0, 1'b1, 1'b0});
    // Stray endcommand during drain must not produce read data
    for (int n = 1; n <= DC; n++) begin
      endcommand = (n == 2);
      data_out   = 16'hDEAD;
      tick();
      chk($sformatf("drain%0d", n), {busy, rd_valid, rd_data}, {1'b1, 1'b0, 16'h0});
    end
    endcommand = 1'b0;
    tick();
    chk("drain_exit", {busy, rd_valid}, 2'b00);

`ifdef PSRAM_SCHED_WATCHDOG_EN
    // Suppressed endcommand: err after WDOG_CYCLES busy cycles, no rd_valid
    rd_req = 1'b1; rd_addr = 23'h40;
    wait_quad("wdog_start", rw, bm);
    rd_req = 1'b0;
    repeat (WD - 1) tick();
    chk("wdog_before", {err, busy}, 2'b01);
    tick();
    chk("wdog_fire", {err, busy, rd_valid, read_write}, {1'b1, 1'b1, 1'b0, 2'd0});
    endcommand = 1'b1;
    tick();
    endcommand = 1'b0;
    chk("wdog_no_valid", {rd_valid, err}, 2'b01);
`else
    // No watchdog: read waits indefinitely, then completes normally
    rd_req = 1'b1; rd_addr = 23'h40;
    wait_quad("long_read_start", rw, bm);
    rd_req = 1'b0;
    repeat (40) tick();
    chk("long_read_wait", {busy, err, rd_valid}, 3'b100);
    data_out   = 16'h5A5A;
    endcommand = 1'b1;
    tick();
    endcommand = 1'b0;
    chk("long_read_done", {rd_valid, rd_data, err}, {1'b1, 16'h5A5A, 1'b0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
